// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-memory bus and decode-stage handshake for inst_fetch.
// Rev 1.0 -- initial release.
`default_nettype none

interface inst_fetch_if;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [63:0] inst_addr_o;
  logic        inst_valid_o;
  logic        hold_flag_i;
  logic        jump_flag_i;
  logic [63:0] jump_addr_i;

  modport master (
    output imem_req_o, imem_addr_o, inst_o, inst_addr_o, inst_valid_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, hold_flag_i, jump_flag_i, jump_addr_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, inst_o, inst_addr_o, inst_valid_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, hold_flag_i, jump_flag_i, jump_addr_i
  );
endinterface

`default_nettype wire

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch with a 2-entry output FIFO.
// Optional IFU_MISALIGN_EXC_EN adds misalign_o. Rev 1.0 -- initial release.
`default_nettype none

module inst_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  wire logic   clk,
  input  wire logic   rst,
  inst_fetch_if.master bus
`ifdef IFU_MISALIGN_EXC_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_req_addr;
  logic [63:0] r_addr [0:1];
  logic [31:0] r_inst [0:1];
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic        w_pop;
  logic        w_push;
  logic        w_wr_ptr;
  logic [1:0]  w_cnt_after_pop;
  logic [1:0]  w_cnt_next;
  logic [63:0] w_jump_target;

  assign w_pop           = (r_count != 2'd0) && !bus.hold_flag_i;
  assign w_push          = (r_state == S_WAIT) && bus.imem_rvalid_i;
  assign w_wr_ptr        = r_rd_ptr ^ r_count[0];
  assign w_cnt_after_pop = r_count - {1'b0, w_pop};
  assign w_cnt_next      = w_cnt_after_pop + {1'b0, w_push};
  assign w_jump_target   = {bus.jump_addr_i[63:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else if (bus.jump_flag_i) begin
      // Redirect flushes the FIFO; an in-flight response must be swallowed in DROP.
      r_count <= 2'd0;
      r_pc    <= w_jump_target;
      case (r_state)
        S_IDLE:  r_state <= S_REQ;
        S_REQ:   r_state <= bus.imem_gnt_i ? S_DROP : S_REQ;
        S_WAIT:  r_state <= bus.imem_rvalid_i ? S_REQ : S_DROP;
        S_DROP:  r_state <= bus.imem_rvalid_i ? S_REQ : S_DROP;
        default: r_state <= S_IDLE;
      endcase
    end else begin
      r_count <= w_cnt_next;
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case (r_state)
        S_IDLE: begin
          if (w_cnt_after_pop < 2'd2) begin
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.imem_gnt_i) begin
            r_state    <= S_WAIT;
            r_req_addr <= r_pc;
            r_pc       <= r_pc + 64'd4;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid_i) begin
            r_state <= (w_cnt_next < 2'd2) ? S_REQ : S_IDLE;
          end
        end
        S_DROP: begin
          if (bus.imem_rvalid_i) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Payload storage needs no reset: it is only visible through a non-zero count.
  always_ff @(posedge clk) begin
    if (w_push && !bus.jump_flag_i) begin
      r_addr[w_wr_ptr] <= r_req_addr;
      r_inst[w_wr_ptr] <= bus.imem_rdata_i;
    end
  end

  assign bus.imem_req_o   = (r_state == S_REQ);
  assign bus.imem_addr_o  = r_pc;
  assign bus.inst_valid_o = (r_count != 2'd0);
  assign bus.inst_o       = bus.inst_valid_o ? r_inst[r_rd_ptr] : NOP_INST;
  assign bus.inst_addr_o  = bus.inst_valid_o ? r_addr[r_rd_ptr] : 64'd0;

`ifdef IFU_MISALIGN_EXC_EN
  logic r_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= bus.jump_flag_i && (bus.jump_addr_i[1:0] != 2'b00);
    end
  end

  assign misalign_o = r_misalign;
`else
  logic w_unused_jump_lsb;
  assign w_unused_jump_lsb = ^bus.jump_addr_i[1:0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed stimulus with a queue scoreboard for inst_fetch.
// Rev 1.0 -- initial release.
`default_nettype none

module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst;

  inst_fetch_if bus();

`ifdef IFU_MISALIGN_EXC_EN
  logic misalign;
`endif

  inst_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IFU_MISALIGN_EXC_EN
    ,
    .misalign_o (misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] inst;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [63:0] gnt_log[$];
  bit          resp_en = 1'b1;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return {a[15:0] ^ 16'hA5A5, 16'h0033};
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [63:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.inst = d;
    exp_q.push_back(e);
  endtask

  task automatic fetch_one();
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d entries still pending, required 0", name, exp_q.size());
    end
  endtask

  // Memory model: answers one cycle after each grant while resp_en is set.
  initial begin
    logic        w;
    logic [63:0] a;
    forever begin
      @(negedge clk);
      w = bus.imem_req_o && bus.imem_gnt_i && (rst === 1'b0);
      a = bus.imem_addr_o;
      if (w) gnt_log.push_back(a);
      @(posedge clk);
      #2;
      if (resp_en) begin
        bus.imem_rvalid_i = w;
        bus.imem_rdata_i  = w ? mem_data(a) : 32'h0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus.inst_valid_o && !bus.hold_flag_i && !bus.jump_flag_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got addr %h inst %h, required no output",
                 bus.inst_addr_o, bus.inst_o);
      end else begin
        e = exp_q.pop_front();
        check64("out_addr", bus.inst_addr_o, e.addr);
        check64("out_inst", {32'h0, bus.inst_o}, {32'h0, e.inst});
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.hold_flag_i   = 1'b0;
    bus.jump_flag_i   = 1'b0;
    bus.jump_addr_i   = 64'h0;
    repeat (3) tick();
    check64("rst_req", {63'h0, bus.imem_req_o}, 64'h0);
    check64("rst_addr", bus.imem_addr_o, 64'h8000_0000);
    check64("rst_valid", {63'h0, bus.inst_valid_o}, 64'h0);
    check64("rst_inst", {32'h0, bus.inst_o}, 64'h13);
    check64("rst_inst_addr", bus.inst_addr_o, 64'h0);
`ifdef IFU_MISALIGN_EXC_EN
    check64("rst_misalign", {63'h0, misalign}, 64'h0);
`endif

    // Release with a stale rvalid present; first request must appear one edge later.
    rst = 1'b0;
    resp_en = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'hBAD0_0BAD;
    check64("idle_req", {63'h0, bus.imem_req_o}, 64'h0);
    tick();
    bus.imem_rvalid_i = 1'b0;
    resp_en = 1'b1;
    check64("stale_valid", {63'h0, bus.inst_valid_o}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      check64("nogrant_req", {63'h0, bus.imem_req_o}, 64'h1);
      check64("nogrant_addr", bus.imem_addr_o, 64'h8000_0000);
      tick();
    end

    push_exp(64'h8000_0000, 32'hA5A5_0033);
    push_exp(64'h8000_0004, 32'hA5A1_0033);
    push_exp(64'h8000_0008, 32'hA5AD_0033);
    bus.imem_gnt_i = 1'b1;
    n = 0;
    while (gnt_log.size() < 3 && n < 30) begin
      tick();
      n++;
    end
    bus.imem_gnt_i = 1'b0;
    wait_drain("seq_drain");
    check64("gnt_count", 64'(gnt_log.size()), 64'd3);
    if (gnt_log.size() >= 3) begin
      check64("gnt_addr0", gnt_log[0], 64'h8000_0000);
      check64("gnt_addr1", gnt_log[1], 64'h8000_0004);
      check64("gnt_addr2", gnt_log[2], 64'h8000_0008);
    end

    // Stall: FIFO fills to two, fetching stops, head stays put.
    push_exp(64'h8000_000C, 32'hA5A9_0033);
    push_exp(64'h8000_0010, 32'hA5B5_0033);
    bus.hold_flag_i = 1'b1;
    bus.imem_gnt_i  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i >= 1) check64("hold_head_addr", bus.inst_addr_o, 64'h8000_000C);
    end
    check64("hold_req", {63'h0, bus.imem_req_o}, 64'h0);
    check64("hold_valid", {63'h0, bus.inst_valid_o}, 64'h1);
    check64("hold_inst", {32'h0, bus.inst_o}, {32'h0, 32'hA5A9_0033});
    bus.hold_flag_i = 1'b0;
    bus.imem_gnt_i  = 1'b0;
    tick();
    check64("drain1_valid", {63'h0, bus.inst_valid_o}, 64'h1);
    check64("drain1_addr", bus.inst_addr_o, 64'h8000_0010);
    tick();
    check64("drain2_valid", {63'h0, bus.inst_valid_o}, 64'h0);

    // Jump while a response is outstanding; the late response must vanish.
    resp_en = 1'b0;
    fetch_one();
    bus.jump_flag_i = 1'b1;
    bus.jump_addr_i = 64'h8000_1000;
    tick();
    bus.jump_flag_i   = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid_i = 1'b0;
    resp_en = 1'b1;
    check64("jmp_wait_valid", {63'h0, bus.inst_valid_o}, 64'h0);
    check64("jmp_wait_req", {63'h0, bus.imem_req_o}, 64'h1);
    check64("jmp_wait_addr", bus.imem_addr_o, 64'h8000_1000);
    push_exp(64'h8000_1000, 32'hB5A5_0033);
    fetch_one();
    wait_drain("jmp_drain");

    // Jump together with hold flushes a held entry.
    bus.hold_flag_i = 1'b1;
    fetch_one();
    tick();
    check64("jh_pre_valid", {63'h0, bus.inst_valid_o}, 64'h1);
    check64("jh_pre_addr", bus.inst_addr_o, 64'h8000_1004);
    bus.jump_flag_i = 1'b1;
    bus.jump_addr_i = 64'h8000_2000;
    tick();
    bus.jump_flag_i = 1'b0;
    bus.hold_flag_i = 1'b0;
    check64("jh_valid", {63'h0, bus.inst_valid_o}, 64'h0);
    check64("jh_pc", bus.imem_addr_o, 64'h8000_2000);

    // Misaligned target is aligned down.
    bus.jump_flag_i = 1'b1;
    bus.jump_addr_i = 64'h8000_0006;
    tick();
    bus.jump_flag_i = 1'b0;
    check64("mis_addr", bus.imem_addr_o, 64'h8000_0004);
    check64("mis_req", {63'h0, bus.imem_req_o}, 64'h1);
`ifdef IFU_MISALIGN_EXC_EN
    check64("mis_pulse", {63'h0, misalign}, 64'h1);
`endif
    tick();
`ifdef IFU_MISALIGN_EXC_EN
    check64("mis_pulse_end", {63'h0, misalign}, 64'h0);
`endif
    push_exp(64'h8000_0004, 32'hA5A1_0033);
    fetch_one();
    wait_drain("mis_drain");

    // Reset during an outstanding transaction.
    fetch_one();
    rst = 1'b1;
    tick();
    check64("mid_rst_req", {63'h0, bus.imem_req_o}, 64'h0);
    check64("mid_rst_valid", {63'h0, bus.inst_valid_o}, 64'h0);
    check64("mid_rst_addr", bus.imem_addr_o, 64'h8000_0000);
    rst = 1'b0;
    resp_en = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'hBAD0_0BAD;
    tick();
    bus.imem_rvalid_i = 1'b0;
    resp_en = 1'b1;
    check64("post_rst_req", {63'h0, bus.imem_req_o}, 64'h1);
    check64("post_rst_addr", bus.imem_addr_o, 64'h8000_0000);
    tick();
    check64("post_rst_valid", {63'h0, bus.inst_valid_o}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, is the PC value loaded at reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, is the instruction driven on inst_o while inst_valid_o is low.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 imem_req_o  output  1  instruction-memory request.
REQ-006 imem_addr_o  output  64  request address; word aligned.
REQ-007 imem_gnt_i  input  1  request accepted this cycle.
REQ-008 imem_rvalid_i  input  1  response data valid.
REQ-009 imem_rdata_i  input  32  response instruction.
REQ-010 inst_o  output  32  instruction to the decode stage.
REQ-011 inst_addr_o  output  64  address of inst_o.
REQ-012 inst_valid_o  output  1  inst_o/inst_addr_o are valid.
REQ-013 hold_flag_i  input  1  decode-stage stall (load-use); the current output is not consumed.
REQ-014 jump_flag_i  input  1  redirect request from execute.
REQ-015 jump_addr_i  input  64  redirect target.
REQ-016 misalign_o  output  1  misaligned redirect pulse; the port exists only under IFU_MISALIGN_EXC_EN.

Function
REQ-017 The block SHALL keep a 2-entry FIFO of {addr, inst} and a count of 0..2; inst_valid_o = (count != 0), and inst_o/inst_addr_o show the head entry.
REQ-018 The head SHALL pop on the edge where inst_valid_o=1 and hold_flag_i=0; while hold_flag_i=1, the outputs SHALL stay stable.
REQ-019 At most one memory transaction SHALL be outstanding, tracked by the FSM states IDLE, REQ, WAIT and DROP.
REQ-020 IDLE: imem_req_o=0; the FSM goes to REQ when count (after this cycle's pop) < 2.
REQ-021 REQ: imem_req_o=1 and imem_addr_o=pc. On imem_gnt_i the FSM goes to WAIT and pc += 4 (64-bit wrap). Without a grant it holds REQ with imem_addr_o unchanged.
REQ-022 WAIT: on imem_rvalid_i the block pushes {request addr, imem_rdata_i}. It then goes to REQ if the post-push/pop count < 2, otherwise to IDLE.
REQ-023 DROP: imem_rvalid_i data is discarded, and the FSM then goes to REQ.
REQ-024 A push and a pop in the same cycle SHALL leave count unchanged; a push never occurs when count = 2, because REQ is entered only with a free slot.
REQ-025 jump_flag_i=1 SHALL clear the FIFO (count=0, inst_valid_o=0 next cycle) and load pc with {jump_addr_i[63:2], 2'b00}. jump_flag_i overrides hold_flag_i and any pop.
REQ-026 State change on jump_flag_i:
- jump in IDLE -> REQ.
- jump in REQ without grant -> REQ with the new pc next cycle.
- jump in REQ with grant -> DROP.
- jump in WAIT without rvalid -> DROP.
- jump in WAIT with rvalid -> data discarded, REQ.
- jump in DROP without rvalid -> DROP.
- jump in DROP with rvalid -> REQ.
REQ-027 The output path is registered FIFO state, so fetch-to-output latency is 1 cycle after imem_rvalid_i.

Reset
REQ-028 While rst=1:
- pc=RESET_PC, FSM=IDLE, count=0
- imem_req_o=0, imem_addr_o=RESET_PC
- inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0
- misalign_o=0
REQ-029 Reset asserted mid-transaction SHALL abandon it. After release, the first request SHALL go out in cycle 2 (IDLE -> REQ), and any stale imem_rvalid_i with no outstanding transaction SHALL be ignored.

Configuration
REQ-030 With IFU_MISALIGN_EXC_EN defined, misalign_o SHALL pulse high for the one cycle after a jump with jump_addr_i[1:0] != 0; the redirect itself proceeds per REQ-025.
REQ-031 Without IFU_MISALIGN_EXC_EN, the misalign_o port and its logic SHALL be absent, and misaligned targets are silently aligned.

Verification
REQ-032 Reset release with gnt=1 and rvalid one cycle after each grant -> addresses 0x80000000, 0x80000004, 0x80000008 are requested in order, and the matching inst_o/inst_addr_o appear in order.
REQ-033 hold_flag_i=1 for 5 cycles with memory responding -> count saturates at 2, imem_req_o=0 (IDLE), and inst_o stays stable; on release, both entries drain in consecutive cycles.
REQ-034 jump_flag_i=1, jump_addr_i=0x80001000 during WAIT -> the late rvalid data (0xDEADBEEF) is never output, and the next request goes to 0x80001000.
REQ-035 jump_flag_i=1 and hold_flag_i=1 in the same cycle -> the FIFO is empty next cycle and pc=target.
REQ-036 imem_gnt_i held low for 4 cycles in REQ -> imem_addr_o stays at 0x80000000 throughout, and pc does not advance.
REQ-037 With IFU_MISALIGN_EXC_EN, a jump to 0x80000006 -> misalign_o=1 for one cycle and the next request goes to 0x80000004.
